// File: rtl/precomp_loader_448.sv
// precomp_loader_448: loads the x/y/t precomputed-point tables at runtime.
// Host words are assembled into 448-bit coordinates, least significant word
// first. Each coordinate is written with a one-cycle strobe. Coordinates are
// written in the order x, y, t for each entry, until entry ENTRIES-1 is done.
// Optional feature macro: PRECOMP_LOADER_CHECKSUM_EN. When it is defined,
// the loader takes one extra trailing word and checks it against a 32-bit
// wrapping sum of all accepted data words.
module precomp_loader_448 #(
  parameter int ENTRIES = 1792,
  parameter int WORDS   = 14,
  parameter int ADDR_W  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [32*WORDS-1:0]   wr_data,
  output logic                  wr_x_en,
  output logic                  wr_y_en,
  output logic                  wr_t_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int WCNT_W = $clog2(WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3
`ifdef PRECOMP_LOADER_CHECKSUM_EN
    ,CHECK = 3'd4
`endif
  } state_t;

  typedef enum logic [1:0] {
    COORD_X = 2'd0,
    COORD_Y = 2'd1,
    COORD_T = 2'd2
  } coord_t;

  state_t              state;
  coord_t              coord;
  logic [WCNT_W-1:0]   word_cnt;
  logic [ADDR_W-1:0]   entry;
`ifdef PRECOMP_LOADER_CHECKSUM_EN
  logic [31:0]         sum;
`else
  assign error = 1'b0;
`endif

  // Control FSM with registered outputs: handshake, assembly and write strobes.
  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // register samples its inputs from before the edge.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous, so it is simply the first branch inside
    // the clocked block and is not in the sensitivity list.
    if (rst) begin
      state    <= IDLE;
      coord    <= COORD_X;
      word_cnt <= '0;
      entry    <= '0;
      s_ready  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_x_en  <= 1'b0;
      wr_y_en  <= 1'b0;
      wr_t_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef PRECOMP_LOADER_CHECKSUM_EN
      sum      <= '0;
      error    <= 1'b0;
`endif
    end else begin
      // NOTE: strobes default low each cycle. Only the LOAD completion below
      // raises one, so each strobe lasts exactly one cycle.
      wr_x_en <= 1'b0;
      wr_y_en <= 1'b0;
      wr_t_en <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            coord    <= COORD_X;
            word_cnt <= '0;
            entry    <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
            s_ready  <= 1'b1;
`ifdef PRECOMP_LOADER_CHECKSUM_EN
            sum      <= '0;
            error    <= 1'b0;
`endif
            state    <= LOAD;
          end
        end

        LOAD: begin
          if (s_valid && s_ready) begin
            wr_data[32*int'(word_cnt) +: 32] <= s_data;
`ifdef PRECOMP_LOADER_CHECKSUM_EN
            sum <= sum + s_data;
`endif
            if (word_cnt == WCNT_W'(WORDS - 1)) begin
              // Last word of the coordinate: drop ready and strobe the next cycle.
              word_cnt <= '0;
              s_ready  <= 1'b0;
              wr_addr  <= entry;
              case (coord)
                COORD_X: wr_x_en <= 1'b1;
                COORD_Y: wr_y_en <= 1'b1;
                default: wr_t_en <= 1'b1;
              endcase
              state    <= WRITE;
            end else begin
              word_cnt <= word_cnt + WCNT_W'(1);
            end
          end
        end

        WRITE: begin
          case (coord)
            COORD_X: begin
              coord   <= COORD_Y;
              s_ready <= 1'b1;
              state   <= LOAD;
            end
            COORD_Y: begin
              coord   <= COORD_T;
              s_ready <= 1'b1;
              state   <= LOAD;
            end
            default: begin
              coord <= COORD_X;
              if (entry == ADDR_W'(ENTRIES - 1)) begin
`ifdef PRECOMP_LOADER_CHECKSUM_EN
                s_ready <= 1'b1;
                state   <= CHECK;
`else
                busy    <= 1'b0;
                done    <= 1'b1;
                state   <= DONE;
`endif
              end else begin
                entry   <= entry + ADDR_W'(1);
                s_ready <= 1'b1;
                state   <= LOAD;
              end
            end
          endcase
        end

`ifdef PRECOMP_LOADER_CHECKSUM_EN
        CHECK: begin
          // The trailing word is a checksum, not table data, so it is not summed.
          if (s_valid && s_ready) begin
            error   <= (s_data != sum);
            done    <= 1'b1;
            busy    <= 1'b0;
            s_ready <= 1'b0;
            state   <= DONE;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_precomp_loader_448.sv
// Self-checking bench for precomp_loader_448.
// A reduced instance (ENTRIES=2) runs directed, table-driven loads and the
// corner cases. In parallel, a full-size instance is loaded with random words
// and checked against a scoreboard.
module tb_precomp_loader_448;

`ifdef PRECOMP_LOADER_CHECKSUM_EN
  localparam int DONE_LAT = 91;
`else
  localparam int DONE_LAT = 90;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reduced instance
  logic         rst, start, s_valid, s_ready;
  logic [31:0]  s_data;
  logic [10:0]  wr_addr;
  logic [447:0] wr_data;
  logic         wr_x_en, wr_y_en, wr_t_en, busy, done, error;

  // Full-size instance
  logic         b_rst, b_start, b_valid, b_ready;
  logic [31:0]  b_data;
  logic [10:0]  b_addr;
  logic [447:0] b_wdata;
  logic         b_x_en, b_y_en, b_t_en, b_busy, b_done, b_error;

  precomp_loader_448 #(.ENTRIES(2)) dut_small (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_x_en(wr_x_en), .wr_y_en(wr_y_en), .wr_t_en(wr_t_en),
    .busy(busy), .done(done), .error(error)
  );

  precomp_loader_448 dut_full (
    .clk(clk), .rst(b_rst), .start(b_start), .s_data(b_data), .s_valid(b_valid),
    .s_ready(b_ready), .wr_addr(b_addr), .wr_data(b_wdata),
    .wr_x_en(b_x_en), .wr_y_en(b_y_en), .wr_t_en(b_t_en),
    .busy(b_busy), .done(b_done), .error(b_error)
  );

  typedef struct {
    logic [2:0]  en;      // {t, y, x}
    logic [10:0] addr;
    int          offset;  // first word of the coordinate, relative to the load base
  } vec_t;

  typedef struct {
    logic [2:0]   en;
    logic [10:0]  addr;
    logic [447:0] data;
  } ev_t;

  vec_t table_v[6];
  ev_t  ev_q[$];
  ev_t  exp_q[$];
  ev_t  b_exp;
  bit   chk_ready = 1'b0;
  bit   big_active = 1'b0;
  int   busy_drops = 0;
  int   b_strobe_cnt = 0;

  task automatic check(input string name, input logic [447:0] act, input logic [447:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [447:0] coord_of(input logic [31:0] first);
    logic [447:0] d;
    d = '0;
    for (int k = 0; k < 14; k++) d[32*k +: 32] = first + 32'(k);
    return d;
  endfunction

  // Records every strobe of the reduced instance and, when enabled, checks
  // that ready is low exactly in the write cycles of a load.
  always @(negedge clk) begin
    if (wr_x_en | wr_y_en | wr_t_en)
      ev_q.push_back('{en: {wr_t_en, wr_y_en, wr_x_en}, addr: wr_addr, data: wr_data});
    if (chk_ready && busy)
      check("s2_ready_only_drops_in_write", s_ready, !(wr_x_en | wr_y_en | wr_t_en));
  end

  // Scoreboard for the full-size instance.
  always @(negedge clk) begin
    if (b_x_en | b_y_en | b_t_en) begin
      b_strobe_cnt++;
      check("big_onehot", $onehot({b_t_en, b_y_en, b_x_en}), 1);
      if (exp_q.size() == 0) begin
        check("big_unexpected_strobe", {b_t_en, b_y_en, b_x_en}, 0);
      end else begin
        b_exp = exp_q.pop_front();
        check("big_en", {b_t_en, b_y_en, b_x_en}, b_exp.en);
        check("big_addr", b_addr, b_exp.addr);
        check("big_data", b_wdata, b_exp.data);
      end
    end
    if (big_active && !b_busy && !b_done) busy_drops++;
  end

  task automatic push_word(input logic [31:0] w, input bit gap);
    int budget;
    if (gap) begin
      s_valid = 1'b0;
      step();
    end
    s_valid = 1'b1;
    s_data  = w;
    budget  = 50;
    while (!s_ready && budget > 0) begin
      step();
      budget--;
    end
    if (!s_ready) check("push_ready_timeout", s_ready, 1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic push_big(input logic [31:0] w);
    int budget;
    b_valid = 1'b1;
    b_data  = w;
    budget  = 50;
    while (!b_ready && budget > 0) begin
      step();
      budget--;
    end
    if (!b_ready) check("big_ready_timeout", b_ready, 1);
    step();
    b_valid = 1'b0;
  endtask

  // One complete ENTRIES=2 load of words base..base+83, checked against table_v.
  task automatic run_load(input logic [31:0] base, input bit gap, input bit mid_start,
                          input bit bad_csum, input string tag);
    int t0;
    int budget;
    logic [31:0] sum;
    logic exp_err;
    ev_q.delete();
    sum = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_ready_rise"}, s_ready, 1);
    check({tag, "_busy_rise"}, busy, 1);
    check({tag, "_done_clear"}, done, 0);
    t0 = cyc;
    for (int k = 0; k < 84; k++) begin
      push_word(base + 32'(k), gap);
      sum = sum + base + 32'(k);
      if (mid_start && k == 20) begin
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy_after_ignored_start"}, busy, 1);
        check({tag, "_ready_after_ignored_start"}, s_ready, 1);
      end
    end
`ifdef PRECOMP_LOADER_CHECKSUM_EN
    push_word(bad_csum ? 32'h0 : sum, gap);
    exp_err = bad_csum;
`else
    exp_err = 1'b0;
`endif
    budget = 50;
    while (!done && budget > 0) begin
      step();
      budget--;
    end
    check({tag, "_done"}, done, 1);
    if (!gap && !mid_start) check({tag, "_done_cycle"}, cyc - t0, DONE_LAT);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_ready_low"}, s_ready, 0);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_strobe_count"}, ev_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < ev_q.size()) begin
        check($sformatf("%s_en%0d", tag, i), ev_q[i].en, table_v[i].en);
        check($sformatf("%s_addr%0d", tag, i), ev_q[i].addr, table_v[i].addr);
        check($sformatf("%s_data%0d", tag, i), ev_q[i].data,
              coord_of(base + 32'(table_v[i].offset)));
      end
    end
  endtask

  task automatic small_seq();
    table_v[0] = '{en: 3'b001, addr: 11'd0, offset: 0};
    table_v[1] = '{en: 3'b010, addr: 11'd0, offset: 14};
    table_v[2] = '{en: 3'b100, addr: 11'd0, offset: 28};
    table_v[3] = '{en: 3'b001, addr: 11'd1, offset: 42};
    table_v[4] = '{en: 3'b010, addr: 11'd1, offset: 56};
    table_v[5] = '{en: 3'b100, addr: 11'd1, offset: 70};

    // Continuous stream of words 1..84.
    run_load(32'd1, 1'b0, 1'b0, 1'b0, "s1");

    // Valid toggling: same writes, stretched timing.
    chk_ready = 1'b1;
    run_load(32'd1, 1'b1, 1'b0, 1'b0, "s2");
    chk_ready = 1'b0;

    // Start during LOAD is ignored.
    run_load(32'd1, 1'b0, 1'b1, 1'b0, "s4");

    // Words offered in DONE are not consumed.
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    step();
    step();
    check("s4_done_ready_low", s_ready, 0);
    check("s4_done_held", done, 1);
    s_valid = 1'b0;

    // Start in DONE restarts at address 0.
    ev_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    check("s4_restart_done_clear", done, 0);
    check("s4_restart_busy", busy, 1);
    for (int k = 0; k < 20; k++) push_word(32'h2000 + 32'(k), 1'b0);
    check("s4_restart_strobes", ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      check("s4_restart_en", ev_q[0].en, 3'b001);
      check("s4_restart_addr", ev_q[0].addr, 0);
      check("s4_restart_data", ev_q[0].data, coord_of(32'h2000));
    end

    // Reset after 20 accepted words.
    rst = 1'b1;
    step();
    check("s3_rst_strobes", {wr_t_en, wr_y_en, wr_x_en}, 0);
    check("s3_rst_busy", busy, 0);
    check("s3_rst_ready", s_ready, 0);
    check("s3_rst_wr_data", wr_data, 0);
    check("s3_rst_wr_addr", wr_addr, 0);
    rst = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hCAFEF00D;
    repeat (3) step();
    s_valid = 1'b0;
    check("s3_no_strobe_after_rst", ev_q.size(), 1);
    check("s3_idle_ready", s_ready, 0);

    // Clean load after the reset.
    run_load(32'h3000, 1'b0, 1'b0, 1'b0, "s3");

`ifdef PRECOMP_LOADER_CHECKSUM_EN
    run_load(32'd1, 1'b0, 1'b0, 1'b1, "s5_bad");
`endif
  endtask

  task automatic big_seq();
    logic [447:0] coord;
    logic [31:0]  w;
    logic [31:0]  bsum;
    int           budget;
    bsum = '0;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    big_active = 1'b1;
    for (int e = 0; e < 1792; e++) begin
      for (int c = 0; c < 3; c++) begin
        coord = '0;
        for (int k = 0; k < 14; k++) begin
          w = $urandom;
          coord[32*k +: 32] = w;
          bsum = bsum + w;
        end
        exp_q.push_back('{en: 3'b001 << c, addr: e[10:0], data: coord});
        for (int k = 0; k < 14; k++) push_big(coord[32*k +: 32]);
      end
    end
`ifdef PRECOMP_LOADER_CHECKSUM_EN
    push_big(bsum);
`endif
    budget = 50;
    while (!b_done && budget > 0) begin
      step();
      budget--;
    end
    check("big_done", b_done, 1);
    big_active = 1'b0;
    check("big_error", b_error, 0);
    check("big_strobe_total", b_strobe_cnt, 5376);
    check("big_scoreboard_empty", exp_q.size(), 0);
    check("big_busy_held", busy_drops, 0);
  endtask

  initial begin
    rst = 1'b1;  start = 1'b0;  s_valid = 1'b0;  s_data = '0;
    b_rst = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    repeat (2) step();
    check("rst_s_ready", s_ready, 0);
    check("rst_strobes", {wr_t_en, wr_y_en, wr_x_en}, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    rst = 1'b0;
    b_rst = 1'b0;
    step();
    check("idle_ready_without_start", s_ready, 0);
    fork
      small_seq();
      big_seq();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
